// File: rtl/free_return_arb_pkg.sv
// rtl/free_return_arb_pkg.sv - shared types and defaults for the free-register return path
`include "riscv_core.svh"

package free_return_arb_pkg;

    // Default depth of the retire-to-free-list return queue.
    localparam int RET_Q_DEPTH = 8;

    // Physical register index width and type.
    localparam int PREG_W = $clog2(`NUM_PR);
    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/riscv_core.svh
// rtl/riscv_core.svh - core-wide sizing macros shared by the rename/retire blocks
`ifndef RISCV_CORE_SVH
`define RISCV_CORE_SVH

`define NUM_PR 64

`endif

// File: rtl/free_return_arb.sv
// rtl/free_return_arb.sv - funnels up to two retired physical registers per cycle onto the single free-list write port
module free_return_arb
    import free_return_arb_pkg::*;
#(
    parameter int RQ_DEPTH = RET_Q_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ret_valid [2],
    input  preg_t                     ret_reg   [2],
    input  logic                      fl_ready,
    output logic                      if_freed,
    output preg_t                     freed_reg,
    output logic                      ret_stall,
    output logic [$clog2(RQ_DEPTH):0] rq_count,
    output logic                      idle
);

    localparam int PW = $clog2(RQ_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;

    // Queue storage is never reset; entries are only read while occupied.
    preg_t         rq_mem [RQ_DEPTH];
    ptr_t          head;
    ptr_t          tail;

    logic          push0;
    logic          push1;
    logic          pop;
    ptr_t          slot1;
    logic [CW-1:0] n_push;

    // Outputs and push/pop decisions, all from registered state and current inputs.
    always_comb begin
        if_freed  = (rq_count != '0);
        freed_reg = if_freed ? rq_mem[head] : '0;
        // Two free slots are needed to accept a worst-case dual retire.
        ret_stall = (rq_count > CW'(RQ_DEPTH - 2));
        idle      = (rq_count == '0);

        push0     = !ret_stall && ret_valid[0];
        push1     = !ret_stall && ret_valid[1];
        // Lane1 follows lane0 when both push, otherwise it takes the tail slot itself.
        slot1     = push0 ? (tail + ptr_t'(1)) : tail;
        n_push    = CW'(push0) + CW'(push1);
        pop       = if_freed && fl_ready;
    end

    // Pointer and occupancy state; pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            rq_count <= '0;
        end else begin
            if (pop) begin
                head <= head + ptr_t'(1);
            end
            tail     <= tail + ptr_t'(n_push);
            rq_count <= rq_count + n_push - CW'(pop);
        end
    end

    // Entry writes for the accepted lanes.
    always_ff @(posedge clk) begin
        if (push0) begin
            rq_mem[tail] <= ret_reg[0];
        end
        if (push1) begin
            rq_mem[slot1] <= ret_reg[1];
        end
    end

endmodule

// File: tb/tb_free_return_arb.sv
// tb/tb_free_return_arb.sv - self-checking bench for free_return_arb against a queue reference model
module tb_free_return_arb;
    import free_return_arb_pkg::*;

    localparam int DEPTH = RET_Q_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ret_valid [2];
    preg_t         ret_reg   [2];
    logic          fl_ready;
    logic          if_freed;
    preg_t         freed_reg;
    logic          ret_stall;
    logic [CW-1:0] rq_count;
    logic          idle;

    int mq[$];
    int dut_out[$];
    int n_cmp  = 0;
    int n_fail = 0;

    free_return_arb #(.RQ_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ret_valid (ret_valid),
        .ret_reg   (ret_reg),
        .fl_ready  (fl_ready),
        .if_freed  (if_freed),
        .freed_reg (freed_reg),
        .ret_stall (ret_stall),
        .rq_count  (rq_count),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit v0, input int r0, input bit v1, input int r1, input bit fr);
        ret_valid[0] = v0;
        ret_reg[0]   = preg_t'(r0);
        ret_valid[1] = v1;
        ret_reg[1]   = preg_t'(r1);
        fl_ready     = fr;
    endtask

    // One clock: the reference queue pops the head if the free list takes it,
    // then appends the valid lanes in lane order unless fewer than two slots are free.
    task automatic tick();
        int sz;
        bit stall;
        bit pop;
        sz    = mq.size();
        stall = (DEPTH - sz) < 2;
        pop   = (sz != 0) && fl_ready;
        if (if_freed && fl_ready) dut_out.push_back(int'(freed_reg));
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (!stall) begin
            if (ret_valid[0]) mq.push_back(int'(ret_reg[0]));
            if (ret_valid[1]) mq.push_back(int'(ret_reg[1]));
        end
        @(negedge clk);
    endtask

    task automatic test_drain(input string tag);
        int guard;
        drive(0, 0, 0, 0, 1);
        guard = 0;
        while (mq.size() != 0 && guard < 4 * DEPTH) begin
            n_cmp++;
            if (freed_reg !== mq[0] || if_freed !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_drain: got if_freed=%0b reg=%0d want 1/%0d", tag, if_freed, freed_reg, mq[0]);
            end
            tick();
            guard++;
        end
        n_cmp++;
        if (idle !== 1'b1 || rq_count !== '0) begin
            n_fail++;
            $display("FAIL %s_drained_idle: got idle=%0b count=%0d want 1/0", tag, idle, rq_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        n_cmp++; if (if_freed !== 1'b0) begin n_fail++; $display("FAIL reset_if_freed: got %0b want 0", if_freed); end
        n_cmp++; if (freed_reg !== '0) begin n_fail++; $display("FAIL reset_freed_reg: got %0d want 0", freed_reg); end
        n_cmp++; if (ret_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", ret_stall); end
        n_cmp++; if (rq_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rq_count); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b want 1", idle); end
        reset = 1'b1;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_dual_retire();
        drive(1, 5, 1, 9, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (if_freed !== 1'b1 || freed_reg !== 5) begin n_fail++; $display("FAIL dual_first: got %0b/%0d want 1/5", if_freed, freed_reg); end
        tick();
        n_cmp++; if (if_freed !== 1'b1 || freed_reg !== 9) begin n_fail++; $display("FAIL dual_second: got %0b/%0d want 1/9", if_freed, freed_reg); end
        tick();
        n_cmp++; if (if_freed !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL dual_empty: got if_freed=%0b idle=%0b want 0/1", if_freed, idle); end
    endtask

    task automatic test_lone_lane1();
        drive(0, 0, 1, 12, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (if_freed !== 1'b1 || freed_reg !== 12 || rq_count !== 1) begin
            n_fail++;
            $display("FAIL lone_lane1: got %0b/%0d/%0d want 1/12/1", if_freed, freed_reg, rq_count);
        end
        test_drain("lone_lane1");
    endtask

    // Three pairs leave exactly two free slots, so a fourth pair still fits;
    // the queue is then full and a fifth pair must be dropped.
    task automatic test_fill_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1, 20 + 2 * i, 1, 21 + 2 * i, 0);
            tick();
        end
        n_cmp++; if (rq_count !== 6 || ret_stall !== 1'b0) begin n_fail++; $display("FAIL fill_six: got %0d/%0b want 6/0", rq_count, ret_stall); end
        drive(1, 26, 1, 27, 0);
        tick();
        n_cmp++; if (rq_count !== DEPTH || ret_stall !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0d/%0b want %0d/1", rq_count, ret_stall, DEPTH); end
        drive(1, 40, 1, 41, 0);
        tick();
        n_cmp++; if (rq_count !== DEPTH) begin n_fail++; $display("FAIL fill_ignored: got %0d want %0d", rq_count, DEPTH); end
        test_drain("fill");
    endtask

    // At DEPTH-2 a dual push with a simultaneous pop is fully accepted.
    task automatic test_edge_push_pop();
        for (int i = 0; i < (DEPTH - 2) / 2; i++) begin
            drive(1, 50 + 2 * i, 1, 51 + 2 * i, 0);
            tick();
        end
        drive(1, 60, 1, 61, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (rq_count !== DEPTH - 1 || ret_stall !== 1'b1) begin n_fail++; $display("FAIL edge_push_pop: got %0d/%0b want %0d/1", rq_count, ret_stall, DEPTH - 1); end
        test_drain("edge");
    endtask

    task automatic test_fl_hold();
        drive(1, 7, 1, 8, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_freed !== 1'b1 || freed_reg !== 7 || rq_count !== 2) begin
                n_fail++;
                $display("FAIL hold_%0d: got %0b/%0d/%0d want 1/7/2", i, if_freed, freed_reg, rq_count);
            end
        end
        drive(0, 0, 0, 0, 1);
        tick();
        n_cmp++; if (rq_count !== 1 || freed_reg !== 8) begin n_fail++; $display("FAIL hold_release: got %0d/%0d want 1/8", rq_count, freed_reg); end
        test_drain("hold");
    endtask

    task automatic test_wrap();
        int nxt;
        int guard;
        bit stall;
        dut_out.delete();
        nxt = 0;
        guard = 0;
        while (nxt < 20 && guard < 200) begin
            drive(1, nxt, 0, 0, guard[0]);
            stall = (DEPTH - mq.size()) < 2;
            tick();
            if (!stall) nxt++;
            guard++;
        end
        n_cmp++; if (nxt != 20) begin n_fail++; $display("FAIL wrap_pushes: got %0d want 20", nxt); end
        drive(0, 0, 0, 0, 1);
        guard = 0;
        while (if_freed === 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        n_cmp++; if (dut_out.size() != 20) begin n_fail++; $display("FAIL wrap_len: got %0d want 20", dut_out.size()); end
        for (int i = 0; i < 20 && i < dut_out.size(); i++) begin
            n_cmp++;
            if (dut_out[i] != i) begin n_fail++; $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, dut_out[i], i); end
        end
        mq.delete();
    endtask

    task automatic test_reset_mid();
        drive(1, 30, 1, 31, 0); tick();
        drive(1, 32, 1, 33, 0); tick();
        drive(1, 34, 0, 0, 0);  tick();
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (rq_count !== 5) begin n_fail++; $display("FAIL rmid_count: got %0d want 5", rq_count); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (if_freed !== 1'b0 || rq_count !== '0) begin n_fail++; $display("FAIL rmid_async: got %0b/%0d want 0/0", if_freed, rq_count); end
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 3, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (if_freed !== 1'b1 || freed_reg !== 3 || rq_count !== 1) begin n_fail++; $display("FAIL rmid_first: got %0b/%0d/%0d want 1/3/1", if_freed, freed_reg, rq_count); end
        test_drain("rmid");
    endtask

    task automatic test_random();
        int exp_head;
        for (int c = 0; c < 400; c++) begin
            exp_head = (mq.size() != 0) ? mq[0] : 0;
            n_cmp++;
            if (rq_count !== mq.size() || if_freed !== (mq.size() != 0) || freed_reg !== exp_head
                || ret_stall !== ((DEPTH - mq.size()) < 2) || idle !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL rand_c%0d: got cnt=%0d fr=%0b reg=%0d st=%0b want cnt=%0d reg=%0d",
                         c, rq_count, if_freed, freed_reg, ret_stall, mq.size(), exp_head);
            end
            drive($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1),
                  $urandom_range(0, 63), ($urandom_range(0, 3) != 0));
            tick();
        end
        test_drain("rand");
    endtask

    initial begin
        test_reset();
        test_dual_retire();
        test_lone_lane1();
        test_fill_stall();
        test_edge_push_pop();
        test_fl_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
